// File: rtl/tri_sched_pkg.sv
// Shared types and constants for the triangle job scheduler.
//   state_t      sequencer states
//   job_entry_t  queued job: source flag plus three vertices
//   sat_inc      saturating point-counter increment
package tri_sched_pkg;

  localparam int COORD_W = 3;
  localparam int JOB_W   = 18;
  localparam int CNT_W   = 7;
  localparam int ENTRY_W = JOB_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    V1    = 3'd1,
    V2    = 3'd2,
    V3    = 3'd3,
    WAITB = 3'd4,
    RUN   = 3'd5,
    DONE  = 3'd6
  } state_t;

  typedef struct packed {
    logic               src;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] x3;
    logic [COORD_W-1:0] y3;
  } job_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             en);
    if (en && (c != CNT_MAX)) return c + 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/tri_job_fifo.sv
// Synchronous job FIFO with registered full/empty flags.
//   clk, reset    clock, synchronous active-high reset
//   push, wdata   write strobe and data (ignored when full)
//   pop, rdata    read strobe (ignored when empty); rdata shows the head entry
//   full, empty   registered occupancy flags
//   count         current occupancy
module tri_job_fifo
  import tri_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int OCC_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OCC_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Flags are registered from the next occupancy so they line up with count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == OCC_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tri_sched.sv
// Two-requester triangle job scheduler feeding a rasterizer.
//   clk, reset             clock, synchronous active-high reset
//   req_a/b, job_a/b       requester handshakes and jobs {x1,y1,x2,y2,x3,y3}
//   gnt_a/b                one-cycle accept pulse, job captured that cycle
//   nt, xi, yi             new-triangle strobe and vertex stream to rasterizer
//   eng_busy, eng_po       rasterizer busy and point-valid flags
//   done, done_src,
//   done_cnt, done_err     one-cycle job completion report
//   fifo_full              job queue full
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a queued job; pops the head on exit
// V1    | nt=1, presents vertex 1
// V2    | presents vertex 2
// V3    | presents vertex 3
// WAITB | waiting for eng_busy to rise, bounded by TIMEOUT cycles
// RUN   | rasterizer busy, counting eng_po
// DONE  | done pulse with source, point count and timeout flag
module tri_sched
  import tri_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_a,
  input  logic               req_b,
  input  logic [JOB_W-1:0]   job_a,
  input  logic [JOB_W-1:0]   job_b,
  output logic               gnt_a,
  output logic               gnt_b,
  output logic               nt,
  output logic [COORD_W-1:0] xi,
  output logic [COORD_W-1:0] yi,
  input  logic               eng_busy,
  input  logic               eng_po,
  output logic               done,
  output logic               done_src,
  output logic [CNT_W-1:0]   done_cnt,
  output logic               done_err,
  output logic               fifo_full
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t             state;
  job_entry_t         job_q;
  job_entry_t         fifo_head;
  job_entry_t         vsrc;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [OCC_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               grant_ok;
  logic               prio_b;
  logic [CNT_W-1:0]   pt_cnt;
  logic [CNT_W-1:0]   pt_cnt_inc;
  logic [TMR_W-1:0]   timer;
  logic [COORD_W-1:0] vx;
  logic [COORD_W-1:0] vy;

  // Arbitration: prio_b set means B was not granted last and wins a tie.
  assign grant_ok   = !reset && !fifo_full;
  assign gnt_a      = grant_ok && req_a && (!req_b || !prio_b);
  assign gnt_b      = grant_ok && req_b && (!req_a || prio_b);
  assign push       = gnt_a || gnt_b;
  assign fifo_wdata = {gnt_b, (gnt_b ? job_b : job_a)};
  assign pop        = (state == IDLE) && !fifo_empty;
  assign fifo_head  = job_entry_t'(fifo_rdata);
  assign pt_cnt_inc = sat_inc(pt_cnt, eng_po);

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_b <= 1'b0;
    end else if (gnt_a) begin
      prio_b <= 1'b1;
    end else if (gnt_b) begin
      prio_b <= 1'b0;
    end
  end

  tri_job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Vertex to register for the state being entered. Leaving IDLE the job
  // register is not loaded yet, so vertex 1 comes straight from the FIFO head.
  always_comb begin
    vsrc = (state == IDLE) ? fifo_head : job_q;
    vx   = '0;
    vy   = '0;
    case (state)
      IDLE: begin
        vx = vsrc.x1;
        vy = vsrc.y1;
      end
      V1: begin
        vx = vsrc.x2;
        vy = vsrc.y2;
      end
      V2: begin
        vx = vsrc.x3;
        vy = vsrc.y3;
      end
      default: begin
        vx = '0;
        vy = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      job_q    <= '0;
      pt_cnt   <= '0;
      timer    <= '0;
      nt       <= 1'b0;
      xi       <= '0;
      yi       <= '0;
      done     <= 1'b0;
      done_src <= 1'b0;
      done_cnt <= '0;
      done_err <= 1'b0;
    end else begin
      nt       <= 1'b0;
      done     <= 1'b0;
      done_src <= 1'b0;
      done_cnt <= '0;
      done_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            job_q  <= fifo_head;
            pt_cnt <= '0;
            nt     <= 1'b1;
            xi     <= vx;
            yi     <= vy;
            state  <= V1;
          end
        end
        V1: begin
          xi    <= vx;
          yi    <= vy;
          state <= V2;
        end
        V2: begin
          xi    <= vx;
          yi    <= vy;
          state <= V3;
        end
        V3: begin
          xi    <= '0;
          yi    <= '0;
          timer <= TMR_W'(TIMEOUT - 1);
          state <= WAITB;
        end
        WAITB: begin
          pt_cnt <= pt_cnt_inc;
          if (eng_busy) begin
            state <= RUN;
          end else if (timer == '0) begin
            done     <= 1'b1;
            done_src <= job_q.src;
            done_cnt <= pt_cnt_inc;
            done_err <= 1'b1;
            state    <= DONE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RUN: begin
          pt_cnt <= pt_cnt_inc;
          // A point reported in the busy-falling cycle still belongs to this job.
          if (!eng_busy) begin
            done     <= 1'b1;
            done_src <= job_q.src;
            done_cnt <= pt_cnt_inc;
            done_err <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_occ_consistent: assert property (@(posedge clk) disable iff (reset)
    fifo_empty == (fifo_count == '0));

endmodule

// File: tb/tb_tri_sched.sv
module tb_tri_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [17:0] job_a = '0;
  logic [17:0] job_b = '0;
  logic        eng_busy = 1'b0;
  logic        eng_po = 1'b0;
  logic        gnt_a, gnt_b, nt, done, done_src, done_err, fifo_full;
  logic [2:0]  xi, yi;
  logic [6:0]  done_cnt;

  int total = 0;
  int bad = 0;

  int          exp_gnt[$];
  logic [17:0] exp_vtx[$];
  int          exp_done[$];
  int          vphase = 0;
  logic [17:0] cur_v = '0;

  tri_sched #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .job_a(job_a), .job_b(job_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .nt(nt), .xi(xi), .yi(yi),
    .eng_busy(eng_busy), .eng_po(eng_po),
    .done(done), .done_src(done_src), .done_cnt(done_cnt), .done_err(done_err),
    .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] mk(input int x1, input int y1, input int x2,
                                     input int y2, input int x3, input int y3);
    return {x1[2:0], y1[2:0], x2[2:0], y2[2:0], x3[2:0], y3[2:0]};
  endfunction

  function automatic int dpk(input int s, input int c, input int e);
    return s * 256 + c * 2 + e;
  endfunction

  // Monitor: pops expected grants, vertices and done reports as the DUT shows them.
  always @(negedge clk) begin
    if (reset) begin
      vphase = 0;
    end else begin
      chk("gnt_onehot", int'(gnt_a & gnt_b), 0);
      if (gnt_a || gnt_b)
        chk("gnt_src", int'(gnt_b), (exp_gnt.size() > 0) ? exp_gnt.pop_front() : -1);
      if (vphase == 0) begin
        if (nt) begin
          if (exp_vtx.size() == 0) begin
            chk("nt_unexpected", int'(nt), 0);
          end else begin
            cur_v = exp_vtx.pop_front();
            chk("vtx1", int'({xi, yi}), int'(cur_v[17:12]));
            vphase = 1;
          end
        end else begin
          chk("xy_idle", int'({xi, yi}), 0);
        end
      end else begin
        chk("nt_width", int'(nt), 0);
        if (vphase == 1) begin
          chk("vtx2", int'({xi, yi}), int'(cur_v[11:6]));
          vphase = 2;
        end else begin
          chk("vtx3", int'({xi, yi}), int'(cur_v[5:0]));
          vphase = 0;
        end
      end
      if (done)
        chk("done_resp", int'({done_src, done_cnt, done_err}),
            (exp_done.size() > 0) ? exp_done.pop_front() : -1);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic offer(input int src, input logic [17:0] j, output int waited);
    int n;
    if (src == 0) begin req_a = 1'b1; job_a = j; end
    else          begin req_b = 1'b1; job_b = j; end
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if ((src == 0) ? gnt_a : gnt_b) break;
    end
    chk("gnt_timeout", int'(n >= 400), 0);
    waited = n;
    @(posedge clk);
    #1;
    if (src == 0) req_a = 1'b0;
    else          req_b = 1'b0;
  endtask

  task automatic wait_nt(output int ok);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (nt) break;
    end
    chk("nt_timeout", int'(k >= 400), 0);
    ok = (k < 400) ? 1 : 0;
  endtask

  // Rasterizer model: busy with a point every cycle for n cycles from WAITB.
  task automatic engine_job(input int n, input logic last_po);
    int ok;
    wait_nt(ok);
    if (ok == 0) return;
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < n; i++) begin
      eng_busy = 1'b1;
      eng_po = 1'b1;
      @(posedge clk);
      #1;
    end
    eng_busy = 1'b0;
    eng_po = last_po;
    @(posedge clk);
    #1;
    eng_po = 1'b0;
  endtask

  task automatic drain(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
    chk("gnt_q_empty", exp_gnt.size(), 0);
    chk("vtx_q_empty", exp_vtx.size(), 0);
    chk("done_q_empty", exp_done.size(), 0);
  endtask

  initial begin
    int w;
    int ok;
    int n;
    int k;
    int seen;
    logic [17:0] ja[4];
    logic [17:0] jb[4];
    logic [17:0] j3[6];

    // Reset with a request pending: nothing granted, all outputs low.
    reset = 1'b1;
    req_a = 1'b1;
    job_a = mk(1, 2, 3, 4, 5, 6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt_a", int'(gnt_a), 0);
    chk("rst_nt", int'(nt), 0);
    chk("rst_xy", int'({xi, yi}), 0);
    chk("rst_done", int'({done, done_src, done_cnt, done_err}), 0);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_state", int'(dut.state), 0);
    @(posedge clk);
    #1;
    req_a = 1'b0;
    reset = 1'b0;

    // Basic job: (0,0),(4,0),(0,4), 15 busy cycles with points.
    exp_gnt.push_back(0);
    exp_vtx.push_back(mk(0, 0, 4, 0, 0, 4));
    exp_done.push_back(dpk(0, 15, 0));
    fork
      begin
        offer(0, mk(0, 0, 4, 0, 0, 4), w);
        chk("gnt_latency", w, 0);
      end
      engine_job(15, 1'b0);
    join
    drain(4);

    // Both requesters hold 4 jobs: grants alternate A,B; point in busy-fall cycle counts.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ja[i] = mk(i, 1, 2, i, 7, 3);
      jb[i] = mk(6, i, i + 1, 5, 2, 7 - i);
      exp_gnt.push_back(0);
      exp_gnt.push_back(1);
      exp_vtx.push_back(ja[i]);
      exp_vtx.push_back(jb[i]);
      exp_done.push_back(dpk(0, 3, 0));
      exp_done.push_back(dpk(1, 3, 0));
    end
    fork
      for (int i = 0; i < 4; i++) offer(0, ja[i], w);
      for (int i = 0; i < 4; i++) offer(1, jb[i], w);
      for (int i = 0; i < 8; i++) engine_job(2, 1'b1);
    join
    drain(4);

    // Engine stalled: one job in flight plus 4 queued, then full until a pop.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      j3[i] = mk(i, 7 - i, 1, 1, 2, i);
      exp_gnt.push_back(0);
      exp_vtx.push_back(j3[i]);
      exp_done.push_back(dpk(0, (i == 0) ? 40 : 1, 0));
    end
    fork
      for (int i = 0; i < 6; i++) offer(0, j3[i], w);
      begin
        engine_job(40, 1'b0);
        for (int i = 1; i < 6; i++) engine_job(1, 1'b0);
      end
      begin
        n = 0;
        for (k = 0; (k < 200) && (n < 5); k++) begin
          @(negedge clk);
          if (gnt_a) n++;
        end
        chk("grants_before_full", n, 5);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("stall_full", int'(fifo_full), 1);
          chk("stall_no_gnt", int'(gnt_a), 0);
        end
      end
    join
    drain(4);

    // Timeout: busy never rises for the first job, second job runs normally.
    do_reset();
    exp_gnt.push_back(0);
    exp_gnt.push_back(0);
    exp_vtx.push_back(mk(3, 3, 5, 1, 1, 5));
    exp_vtx.push_back(mk(2, 2, 6, 2, 2, 6));
    exp_done.push_back(dpk(0, 0, 1));
    exp_done.push_back(dpk(0, 3, 0));
    fork
      begin
        offer(0, mk(3, 3, 5, 1, 1, 5), w);
        offer(0, mk(2, 2, 6, 2, 2, 6), w);
      end
      begin
        wait_nt(ok);
        for (k = 1; k <= 50; k++) begin
          @(negedge clk);
          if (done) break;
        end
        chk("timeout_latency", k, 11);
        chk("timeout_err", int'(done_err), 1);
        engine_job(3, 1'b0);
      end
    join
    drain(4);

    // Reset during RUN with 2 jobs queued: job aborted, queue flushed.
    do_reset();
    for (int i = 0; i < 3; i++) exp_gnt.push_back(0);
    exp_vtx.push_back(mk(1, 1, 1, 6, 6, 1));
    fork
      begin
        offer(0, mk(1, 1, 1, 6, 6, 1), w);
        offer(0, mk(2, 3, 4, 5, 6, 7), w);
        offer(0, mk(7, 6, 5, 4, 3, 2), w);
      end
      begin
        wait_nt(ok);
        repeat (3) begin @(posedge clk); #1; end
        eng_busy = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("pre_rst_state_run", int'(dut.state), 5);
        reset = 1'b1;
        eng_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_outputs", int'({nt, xi, yi, done, done_cnt, fifo_full}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
    join
    @(negedge clk);
    chk("flush_full", int'(fifo_full), 0);
    chk("flush_empty", int'(dut.u_fifo.empty), 1);
    chk("flush_count", int'(dut.u_fifo.count), 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nt || done) seen++;
    end
    chk("flush_quiet", seen, 0);
    @(posedge clk);
    #1;
    exp_gnt.push_back(0);
    exp_vtx.push_back(mk(4, 5, 6, 7, 0, 1));
    exp_done.push_back(dpk(0, 2, 0));
    fork
      offer(0, mk(4, 5, 6, 7, 0, 1), w);
      engine_job(2, 1'b0);
    join
    drain(4);

    // Saturation: 130 point cycles, and a requester B job.
    do_reset();
    exp_gnt.push_back(1);
    exp_vtx.push_back(mk(7, 7, 1, 2, 3, 4));
    exp_done.push_back(dpk(1, 127, 0));
    fork
      offer(1, mk(7, 7, 1, 2, 3, 4), w);
      engine_job(130, 1'b0);
    join
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
